// File: rtl/vm2002_credit.sv
// Coin credit accumulator for the vm2002 vending machine: coin edge detect, debit grant/deny, coin-per-cycle refund.
// Optional idle auto-refund is enabled by defining VM2002_CREDIT_AUTOREFUND_EN.
module vm2002_credit #(
   parameter logic [15:0] MAX_CREDIT   = 16'd500,
   parameter logic [31:0] IDLE_TIMEOUT = 32'd1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  coins,
   input  logic        cancel,
   input  logic        debit_req,
   input  logic [7:0]  debit_amt,
   output logic [15:0] credit,
   output logic        debit_ack,
   output logic        debit_nack,
   output logic        coin_return,
   output logic        change_valid,
   output logic [1:0]  change_coin,
   output logic        refund_done
);

   localparam int unsigned CW = 16;
   localparam int unsigned XW = CW + 1;
   localparam int unsigned TW = 32;

   localparam logic [1:0] COIN_NONE    = 2'b00;
   localparam logic [1:0] COIN_NICKEL  = 2'b01;
   localparam logic [1:0] COIN_DIME    = 2'b10;
   localparam logic [1:0] COIN_QUARTER = 2'b11;

   typedef enum logic {IDLE, REFUND} state_t;

   state_t        state, state_n;
   logic [1:0]    prev_coin;
   logic [CW-1:0] credit_n;
   logic          debit_ack_n, debit_nack_n, coin_return_n;
   logic          change_valid_n, refund_done_n;
   logic [1:0]    change_coin_n;

   logic          coin_ins;
   logic [CW-1:0] coin_val;
   logic          coin_fits;
   logic          timeout_hit;

   // Insertion is a 00 -> non-zero transition of the sampled coin code
   assign coin_ins  = (coins != COIN_NONE) && (prev_coin == COIN_NONE);
   assign coin_fits = (XW'(credit) + XW'(coin_val)) <= XW'(MAX_CREDIT);

   always_comb begin
      coin_val = '0;
      case (coins)
         COIN_NICKEL:  coin_val = CW'(5);
         COIN_DIME:    coin_val = CW'(10);
         COIN_QUARTER: coin_val = CW'(25);
         default:      coin_val = '0;
      endcase
   end

`ifdef VM2002_CREDIT_AUTOREFUND_EN
   logic [TW-1:0] idle_cnt, idle_cnt_n;

   assign timeout_hit = (state == IDLE) && (credit != '0) && (idle_cnt == IDLE_TIMEOUT);

   // Counts quiet IDLE cycles while money is held; any user activity restarts it
   always_comb begin
      idle_cnt_n = idle_cnt + TW'(1);
      if (state != IDLE || credit == '0 || coin_ins || debit_req || cancel || timeout_hit)
         idle_cnt_n = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt_n;
   end
`else
   logic unused_idle_timeout;

   assign timeout_hit         = 1'b0;
   assign unused_idle_timeout = ^IDLE_TIMEOUT;
`endif

   // Next-state and next-output logic
   always_comb begin
      state_n        = state;
      credit_n       = credit;
      debit_ack_n    = 1'b0;
      debit_nack_n   = 1'b0;
      coin_return_n  = 1'b0;
      change_valid_n = 1'b0;
      change_coin_n  = COIN_NONE;
      refund_done_n  = 1'b0;

      case (state)
         IDLE: begin
            // Coin checked against pre-debit credit, debit against pre-coin credit
            debit_ack_n   = debit_req && !(cancel || timeout_hit) && (credit >= CW'(debit_amt));
            debit_nack_n  = debit_req && !debit_ack_n;
            coin_return_n = coin_ins && !coin_fits;
            credit_n      = CW'(XW'(credit)
                                + ((coin_ins && coin_fits) ? XW'(coin_val) : XW'(0))
                                - (debit_ack_n ? XW'(debit_amt) : XW'(0)));
            if (cancel || timeout_hit)
               state_n = REFUND;
         end

         REFUND: begin
            coin_return_n = coin_ins;
            debit_nack_n  = debit_req;
            if (credit >= CW'(25)) begin
               change_valid_n = 1'b1;
               change_coin_n  = COIN_QUARTER;
               credit_n       = credit - CW'(25);
            end else if (credit >= CW'(10)) begin
               change_valid_n = 1'b1;
               change_coin_n  = COIN_DIME;
               credit_n       = credit - CW'(10);
            end else if (credit >= CW'(5)) begin
               change_valid_n = 1'b1;
               change_coin_n  = COIN_NICKEL;
               credit_n       = credit - CW'(5);
            end else begin
               // Sub-nickel residue cannot be dispensed and is forfeited
               credit_n      = '0;
               refund_done_n = 1'b1;
               state_n       = IDLE;
            end
         end

         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         prev_coin    <= COIN_NONE;
         credit       <= '0;
         debit_ack    <= 1'b0;
         debit_nack   <= 1'b0;
         coin_return  <= 1'b0;
         change_valid <= 1'b0;
         change_coin  <= COIN_NONE;
         refund_done  <= 1'b0;
      end else begin
         state        <= state_n;
         prev_coin    <= coins;
         credit       <= credit_n;
         debit_ack    <= debit_ack_n;
         debit_nack   <= debit_nack_n;
         coin_return  <= coin_return_n;
         change_valid <= change_valid_n;
         change_coin  <= change_coin_n;
         refund_done  <= refund_done_n;
      end
   end

endmodule

// File: tb/tb_vm2002_credit.sv
// Scoreboard bench for vm2002_credit: stimulus pushes expected pulse words, a negedge monitor pops and compares.
module tb_vm2002_credit;

   logic        clk;
   logic        rst;
   logic [1:0]  coins;
   logic        cancel;
   logic        debit_req;
   logic [7:0]  debit_amt;
   logic [15:0] credit;
   logic        debit_ack;
   logic        debit_nack;
   logic        coin_return;
   logic        change_valid;
   logic [1:0]  change_coin;
   logic        refund_done;

   int n_vec = 0;
   int n_err = 0;

   logic [6:0] expq[$];

   vm2002_credit #(
      .MAX_CREDIT   (16'd100),
      .IDLE_TIMEOUT (32'd8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .coins        (coins),
      .cancel       (cancel),
      .debit_req    (debit_req),
      .debit_amt    (debit_amt),
      .credit       (credit),
      .debit_ack    (debit_ack),
      .debit_nack   (debit_nack),
      .coin_return  (coin_return),
      .change_valid (change_valid),
      .change_coin  (change_coin),
      .refund_done  (refund_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Event word: {ack, nack, coin_return, change_valid, refund_done, change_coin}
   function automatic logic [6:0] ev(input logic a, input logic n, input logic r,
                                     input logic v, input logic d, input logic [1:0] c);
      return {a, n, r, v, d, c};
   endfunction

   function automatic logic [6:0] obs_word();
      return {debit_ack, debit_nack, coin_return, change_valid, refund_done, change_coin};
   endfunction

   // Monitor: every cycle presenting any pulse must match the next expected word
   always @(negedge clk) begin
      logic [6:0] got;
      logic [6:0] want;
      if (!rst) begin
         got = obs_word();
         if (got[6:2] != 5'b0) begin
            n_vec++;
            if (expq.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_event got=%b want=none t=%0t", got, $time);
            end else begin
               want = expq.pop_front();
               if (got !== want) begin
                  n_err++;
                  $display("FAIL event got=%b want=%b t=%0t", got, want, $time);
               end
            end
         end
      end
   end

   task automatic step(input logic [1:0] c, input logic can, input logic dr, input logic [7:0] amt);
      coins     = c;
      cancel    = can;
      debit_req = dr;
      debit_amt = amt;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(2'b00, 1'b0, 1'b0, 8'd0);
   endtask

   task automatic chk_credit(input string name, input logic [15:0] want);
      n_vec++;
      if (credit !== want) begin
         n_err++;
         $display("FAIL %s credit got=%0d want=%0d t=%0t", name, credit, want, $time);
      end
   endtask

   task automatic chk_quiet(input string name);
      n_vec++;
      if (obs_word() !== 7'b0) begin
         n_err++;
         $display("FAIL %s outputs got=%b want=0000000", name, obs_word());
      end
   endtask

   initial begin
      rst = 1'b1; coins = 2'b00; cancel = 1'b0; debit_req = 1'b0; debit_amt = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      chk_credit("reset", 16'd0);
      chk_quiet("reset");
      rst = 1'b0;

      // Held coins count once
      step(2'b11, 0, 0, 0); step(2'b11, 0, 0, 0); step(2'b11, 0, 0, 0);
      chk_credit("quarter_held", 16'd25);
      step(2'b00, 0, 0, 0);
      step(2'b10, 0, 0, 0); step(2'b10, 0, 0, 0); step(2'b10, 0, 0, 0);
      chk_credit("dime_held", 16'd35);
      step(2'b00, 0, 0, 0);

      // Debit grant then refuse
      expq.push_back(ev(1, 0, 0, 0, 0, 2'b00));
      step(2'b00, 0, 1, 8'd30);
      chk_credit("debit30_ack", 16'd5);
      expq.push_back(ev(0, 1, 0, 0, 0, 2'b00));
      step(2'b00, 0, 1, 8'd10);
      chk_credit("debit10_nack", 16'd5);

      // Refund 5 cents
      expq.push_back(ev(0, 0, 0, 1, 0, 2'b01));
      expq.push_back(ev(0, 0, 0, 0, 1, 2'b00));
      step(2'b00, 1, 0, 0);
      idle(2);
      chk_credit("refund5", 16'd0);
      idle(1);

      // Ceiling: fifth quarter rejected at MAX_CREDIT=100
      for (int i = 0; i < 4; i++) begin
         step(2'b11, 0, 0, 0);
         step(2'b00, 0, 0, 0);
      end
      chk_credit("four_quarters", 16'd100);
      expq.push_back(ev(0, 0, 1, 0, 0, 2'b00));
      step(2'b11, 0, 0, 0);
      step(2'b00, 0, 0, 0);
      chk_credit("fifth_rejected", 16'd100);

      // Refund 100 cents: four quarters then done
      for (int i = 0; i < 4; i++) expq.push_back(ev(0, 0, 0, 1, 0, 2'b11));
      expq.push_back(ev(0, 0, 0, 0, 1, 2'b00));
      step(2'b00, 1, 0, 0);
      idle(5);
      chk_credit("refund100", 16'd0);

      // Build 42 via a non-multiple-of-5 debit, then refund with coin and debit mid-refund
      step(2'b11, 0, 0, 0); step(2'b00, 0, 0, 0);
      step(2'b11, 0, 0, 0); step(2'b00, 0, 0, 0);
      expq.push_back(ev(1, 0, 0, 0, 0, 2'b00));
      step(2'b00, 0, 1, 8'd8);
      chk_credit("credit42", 16'd42);
      expq.push_back(ev(0, 0, 0, 1, 0, 2'b11));
      expq.push_back(ev(0, 0, 1, 1, 0, 2'b10));
      expq.push_back(ev(0, 1, 0, 1, 0, 2'b01));
      expq.push_back(ev(0, 0, 0, 0, 1, 2'b00));
      step(2'b00, 1, 0, 0);
      step(2'b00, 0, 0, 0);
      chk_credit("refund42_q", 16'd17);
      step(2'b01, 0, 0, 0);
      chk_credit("refund42_d", 16'd7);
      step(2'b00, 0, 1, 8'd1);
      chk_credit("refund42_n", 16'd2);
      step(2'b00, 0, 0, 0);
      chk_credit("refund42_done", 16'd0);

      // Cancel with zero credit
      expq.push_back(ev(0, 0, 0, 0, 1, 2'b00));
      step(2'b00, 1, 0, 0);
      idle(2);
      chk_credit("cancel_zero", 16'd0);

      // Cancel wins over debit (even amt 0); concurrent coin still accepted
      expq.push_back(ev(0, 1, 0, 0, 0, 2'b00));
      expq.push_back(ev(0, 0, 0, 1, 0, 2'b10));
      expq.push_back(ev(0, 0, 0, 0, 1, 2'b00));
      step(2'b10, 1, 1, 8'd0);
      chk_credit("cancel_coin", 16'd10);
      step(2'b00, 0, 0, 0);
      chk_credit("cancel_coin_out", 16'd0);
      idle(1);

      // Coin and debit together; back-to-back debits
      step(2'b10, 0, 0, 0); step(2'b00, 0, 0, 0);
      expq.push_back(ev(1, 0, 0, 0, 0, 2'b00));
      step(2'b11, 0, 1, 8'd10);
      chk_credit("coin_plus_debit", 16'd25);
      expq.push_back(ev(0, 1, 0, 0, 0, 2'b00));
      step(2'b00, 0, 1, 8'd26);
      chk_credit("debit26_nack", 16'd25);
      expq.push_back(ev(1, 0, 0, 0, 0, 2'b00));
      step(2'b00, 0, 1, 8'd25);
      chk_credit("debit25_exact", 16'd0);
      expq.push_back(ev(0, 1, 0, 0, 0, 2'b00));
      step(2'b00, 0, 1, 8'd1);
      chk_credit("debit_empty", 16'd0);
      idle(1);

      // Asynchronous reset mid-refund with credit 35
      step(2'b11, 0, 0, 0); step(2'b00, 0, 0, 0);
      step(2'b10, 0, 0, 0); step(2'b00, 0, 0, 0);
      chk_credit("credit35", 16'd35);
      expq.push_back(ev(0, 0, 0, 1, 0, 2'b11));
      step(2'b00, 1, 0, 0);
      step(2'b00, 0, 0, 0);
      chk_credit("refund35_q", 16'd10);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk_credit("async_reset", 16'd0);
      chk_quiet("async_reset");
      @(posedge clk);
      #1 rst = 1'b0;
      idle(2);
      chk_credit("after_reset", 16'd0);

      // Idle behaviour with a dime held
`ifdef VM2002_CREDIT_AUTOREFUND_EN
      expq.push_back(ev(0, 0, 0, 1, 0, 2'b10));
      expq.push_back(ev(0, 0, 0, 0, 1, 2'b00));
      step(2'b10, 0, 0, 0);
      idle(14);
      chk_credit("autorefund", 16'd0);
`else
      step(2'b10, 0, 0, 0);
      idle(14);
      chk_credit("no_autorefund", 16'd10);
`endif

      idle(3);
      n_vec++;
      if (expq.size() != 0) begin
         n_err++;
         $display("FAIL missing_events got=%0d_pending want=0", expq.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
